// File: rtl/bit_serializer_pkg.sv
// bit_serializer_pkg: FSM state encoding shared by the serializer and its users.
package bit_serializer_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, GAP} ser_state_t;
  localparam ser_state_t ST_RESET = IDLE;
endpackage

// File: rtl/bit_serializer.sv
// bit_serializer: valid/ready word in, one bit per cycle out with cen_out/last_out framing.
// Define BIT_SERIALIZER_PARITY_EN to append an even-parity bit after each word.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 0,
  parameter int MSB_FIRST  = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             dout,
  output logic             cen_out,
  output logic             last_out,
  output logic             busy
);
`ifdef BIT_SERIALIZER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int CW = $clog2(WIDTH);
  localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CMAX = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GMAX = GW'(GAP_CYCLES - 1);
  ser_state_t state_q, state_d, after_word;
  logic [CW-1:0] cnt_q, cnt_d, idx;
  logic [GW-1:0] gap_q, gap_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic dout_q, cen_q, last_q, dout_d, cen_d, last_d, fin, xfer;
  assign fin        = PAR ? state_q == PARITY : (state_q == SHIFT && cnt_q == CMAX);
  assign in_ready   = state_q == IDLE || (fin && GAP_CYCLES == 0);
  assign xfer       = in_valid && in_ready;
  assign after_word = xfer ? SHIFT : (GAP_CYCLES > 0 ? GAP : IDLE);
  assign busy       = state_q != IDLE;
  assign dout       = dout_q;
  assign cen_out    = cen_q;
  assign last_out   = last_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    sh_d    = sh_q;
    case (state_q)
      IDLE: begin
        state_d = xfer ? SHIFT : IDLE;
        cnt_d   = '0;
        sh_d    = xfer ? in_data : sh_q;
      end
      SHIFT: begin
        if (cnt_q != CMAX) begin
          cnt_d = cnt_q + 1'b1;
        end else if (PAR) begin
          state_d = PARITY;
        end else begin
          state_d = after_word;
          cnt_d   = '0;
          gap_d   = '0;
          sh_d    = xfer ? in_data : sh_q;
        end
      end
`ifdef BIT_SERIALIZER_PARITY_EN
      PARITY: begin
        state_d = after_word;
        cnt_d   = '0;
        gap_d   = '0;
        sh_d    = xfer ? in_data : sh_q;
      end
`endif
      GAP: begin
        state_d = gap_q == GMAX ? IDLE : GAP;
        gap_d   = gap_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // Outputs are registered from next state so the first bit lands the cycle after the accepting edge.
  always_comb begin
    idx    = MSB_FIRST != 0 ? CMAX - cnt_d : cnt_d;
    cen_d  = state_d == SHIFT || (PAR && state_d == PARITY);
    dout_d = state_d == SHIFT ? sh_d[idx] : (PAR && state_d == PARITY) ? ^sh_d : 1'b0;
    last_d = PAR ? state_d == PARITY : (state_d == SHIFT && cnt_d == CMAX);
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_RESET;
      cnt_q   <= '0;
      gap_q   <= '0;
      sh_q    <= '0;
      dout_q  <= 1'b0;
      cen_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      sh_q    <= sh_d;
      dout_q  <= dout_d;
      cen_q   <= cen_d;
      last_q  <= last_d;
    end
  end
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: two configurations (no gap/MSB first, 3-cycle gap/LSB first) against a cycle-schedule model.
module tb_bit_serializer;
`ifdef BIT_SERIALIZER_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int N  = 8 + P;
  localparam int MC = 8192;
  logic clk = 1'b0, resetn = 1'b0;
  logic [7:0] in_data [2];
  logic in_valid [2], in_ready [2], dout [2], cen_out [2], last_out [2], busy [2];
  bit e_cen [2][MC], e_dout [2][MC], e_last [2][MC];
  int end_c [2] = '{-100, -100};
  int gapc [2] = '{0, 3};
  bit msbf [2] = '{1, 0};
  int cyc = 0, pass_n = 0, chk_n = 0;
  bit drv_v [2];
  logic [7:0] drv_x [2];
  bit acc [2];
  bit cap [2][$];
  logic [7:0] pend [2][$];
  int n_cen [2], n_last [2], n_gap [2];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  bit_serializer #(.WIDTH(8), .GAP_CYCLES(0), .MSB_FIRST(1)) u0 (
    .clk(clk), .resetn(resetn), .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .dout(dout[0]), .cen_out(cen_out[0]), .last_out(last_out[0]), .busy(busy[0]));
  bit_serializer #(.WIDTH(8), .GAP_CYCLES(3), .MSB_FIRST(0)) u1 (
    .clk(clk), .resetn(resetn), .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .dout(dout[1]), .cen_out(cen_out[1]), .last_out(last_out[1]), .busy(busy[1]));
  task automatic chk(input string nm, input int d, input logic [31:0] a, input logic [31:0] e);
    chk_n++;
    if (a === e) pass_n++;
    else $display("FAIL %s dut%0d cyc=%0d got=%0h exp=%0h", nm, d, cyc, a, e);
  endtask
  task automatic clr_stats();
    for (int d = 0; d < 2; d++) begin
      cap[d].delete();
      n_cen[d] = 0; n_last[d] = 0; n_gap[d] = 0;
    end
  endtask
  // A word accepted while the bench sits in cycle k occupies cycles k+1..k+N; ready/busy follow from the last word's end.
  task automatic step();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      int lim;
      bit r, b;
      lim = end_c[d] + gapc[d];
      r = cyc > lim || (gapc[d] == 0 && cyc == end_c[d]);
      b = cyc <= lim;
      chk("cen_out", d, 32'(cen_out[d]), 32'(e_cen[d][cyc]));
      chk("dout", d, 32'(dout[d]), 32'(e_dout[d][cyc]));
      chk("last_out", d, 32'(last_out[d]), 32'(e_last[d][cyc]));
      chk("in_ready", d, 32'(in_ready[d]), 32'(r));
      chk("busy", d, 32'(busy[d]), 32'(b));
      if (cen_out[d] === 1'b1) begin cap[d].push_back(dout[d]); n_cen[d]++; end
      if (last_out[d] === 1'b1) n_last[d]++;
      if (busy[d] === 1'b1 && cen_out[d] !== 1'b1) n_gap[d]++;
      in_valid[d] = drv_v[d];
      in_data[d]  = drv_x[d];
      acc[d] = drv_v[d] && r;
      if (acc[d]) begin
        for (int i = 0; i < N; i++) begin
          e_cen[d][cyc+1+i]  = 1'b1;
          e_dout[d][cyc+1+i] = i < 8 ? (msbf[d] ? drv_x[d][7-i] : drv_x[d][i]) : ^drv_x[d];
          e_last[d][cyc+1+i] = i == N - 1;
        end
        end_c[d] = cyc + N;
      end
    end
  endtask
  task automatic run_q(input int cycles);
    repeat (cycles) begin
      for (int d = 0; d < 2; d++) begin
        drv_v[d] = pend[d].size() > 0;
        drv_x[d] = drv_v[d] ? pend[d][0] : 8'($urandom);
      end
      step();
      for (int d = 0; d < 2; d++) if (acc[d]) void'(pend[d].pop_front());
    end
  endtask
  initial begin
    logic [7:0] got [2];
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; in_data[d] = 8'h00; drv_v[d] = 1'b0; drv_x[d] = 8'h00;
    end
    repeat (2) step();
    resetn = 1'b1;
    clr_stats();
    pend[0].push_back(8'hA5);
    pend[1].push_back(8'h01);
    run_q(14);
    for (int d = 0; d < 2; d++) begin
      got[d] = 8'h00;
      for (int i = 0; i < 8 && i < cap[d].size(); i++) got[d] = {got[d][6:0], cap[d][i]};
      chk("word_len", d, 32'(n_cen[d]), 32'(N));
      chk("last_cnt", d, 32'(n_last[d]), 32'd1);
    end
    chk("a5_msb_first", 0, 32'(got[0]), 32'h0000_00A5);
    chk("01_lsb_first", 1, 32'(got[1]), 32'h0000_0080);
`ifdef BIT_SERIALIZER_PARITY_EN
    chk("parity_a5", 0, 32'(cap[0][8]), 32'd0);
    chk("parity_01", 1, 32'(cap[1][8]), 32'd1);
`endif
    clr_stats();
    for (int d = 0; d < 2; d++) begin pend[d].push_back(8'hFF); pend[d].push_back(8'h00); end
    run_q(40);
    chk("b2b_cen", 0, 32'(n_cen[0]), 32'(2 * N));
    chk("b2b_last", 0, 32'(n_last[0]), 32'd2);
    chk("b2b_gap", 0, 32'(n_gap[0]), 32'd0);
    chk("gap_cycles", 1, 32'(n_gap[1]), 32'd6);
    chk("gap_last", 1, 32'(n_last[1]), 32'd2);
    repeat (1500) begin
      for (int d = 0; d < 2; d++) begin
        drv_v[d] = $urandom_range(0, 3) != 0;
        drv_x[d] = 8'($urandom);
      end
      step();
    end
    for (int d = 0; d < 2; d++) drv_v[d] = 1'b0;
    repeat (20) step();
    for (int d = 0; d < 2; d++) pend[d].push_back(8'hC3);
    run_q(5);
    @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_cen", d, 32'(cen_out[d]), 32'd0);
      chk("rst_dout", d, 32'(dout[d]), 32'd0);
      chk("rst_last", d, 32'(last_out[d]), 32'd0);
      chk("rst_ready", d, 32'(in_ready[d]), 32'd1);
      chk("rst_busy", d, 32'(busy[d]), 32'd0);
      for (int c = cyc; c < cyc + 24; c++) begin e_cen[d][c] = 1'b0; e_dout[d][c] = 1'b0; e_last[d][c] = 1'b0; end
      end_c[d] = -100;
      drv_v[d] = 1'b0;
    end
    repeat (2) step();
    resetn = 1'b1;
    clr_stats();
    repeat (16) step();
    chk("no_residual", 0, 32'(n_cen[0]), 32'd0);
    chk("no_residual", 1, 32'(n_cen[1]), 32'd0);
    repeat (200) begin
      for (int d = 0; d < 2; d++) begin
        drv_v[d] = $urandom_range(0, 2) != 0;
        drv_x[d] = 8'($urandom);
      end
      step();
    end
    $display("%0d/%0d checks passed", pass_n, chk_n);
    $finish;
  end
endmodule
